// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: FSM states, key map
// and the active-low row decoder.
package keypad_pkg;

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} kp_state_t;

   typedef struct packed {
      logic       single;
      logic [1:0] idx;
   } row_dec_t;

   // Hex code per key, nibble index {row, col}; nibble 0 is row0/col0 ("1").
   localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

   // Exactly one low bit yields single=1 with its index; none or multi yields single=0.
   function automatic row_dec_t row_decode(input logic [3:0] r);
      row_dec_t d;
      d = '{single: 1'b0, idx: 2'd0};
      case (r)
         4'b1110: d = '{single: 1'b1, idx: 2'd0};
         4'b1101: d = '{single: 1'b1, idx: 2'd1};
         4'b1011: d = '{single: 1'b1, idx: 2'd2};
         4'b0111: d = '{single: 1'b1, idx: 2'd3};
         default: d = '{single: 1'b0, idx: 2'd0};
      endcase
      return d;
   endfunction

   function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
      logic [5:0] base;
      base = {r, c, 2'b00};
      return KEY_MAP[base +: 4];
   endfunction

endpackage

// File: rtl/keypad_scan_hex_if.sv
// Keypad pins plus decoded-key outputs. master = scanner, slave = keypad/consumer side.
interface keypad_scan_hex_if;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] key_hex;
   logic       key_valid;
   logic       key_held;

   modport master (input row, output col, key_hex, key_valid, key_held);
   modport slave  (output row, input col, key_hex, key_valid, key_held);
endinterface

// File: rtl/kp_sync2.sv
// Two-flop synchronizer with synchronous reset to all-ones (idle level of pulled-up rows).
module kp_sync2 #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= '1;
         q    <= '1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/keypad_scan_hex.sv
// 4x4 keypad scanner: column strobe, row debounce, hex encode with one-cycle valid.
// Define KEYPAD_REPEAT_EN to add auto-repeat pulses while a key stays held.
module keypad_scan_hex
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV    = 50000,
   parameter int unsigned DB_CNT      = 4,
   parameter int unsigned REPEAT_DLY  = 40,
   parameter int unsigned REPEAT_RATE = 10
) (
   input  logic              clk,
   input  logic              reset,
   keypad_scan_hex_if.master kp
);
   localparam int unsigned SLOT_W = $clog2(SCAN_DIV);
   localparam int unsigned DB_W   = $clog2(DB_CNT + 1);

   if (SCAN_DIV < 4 || DB_CNT < 2 || REPEAT_DLY < 1 || REPEAT_RATE < 1) begin : g_bad_params
      $error("keypad_scan_hex: parameter out of range");
   end

   logic [3:0]        rs;
   row_dec_t          dec;
   kp_state_t         state;
   logic [SLOT_W-1:0] slot_cnt;
   logic [DB_W-1:0]   db_cnt;
   logic [1:0]        col_idx;
   logic [1:0]        cand_row;
   logic [1:0]        cand_col;
   logic [3:0]        col_q;
   logic [3:0]        key_hex_q;
   logic              key_valid_q;
   logic              key_held_q;
   logic              tick_c;
   logic              cand_high_c;
   logic              cand_match_c;
   logic              db_last_c;

`ifdef KEYPAD_REPEAT_EN
   localparam int unsigned RPT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
   localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);
   logic [RPT_W-1:0] rpt_cnt;
   logic             rpt_armed;
`endif

   kp_sync2 #(.WIDTH(4)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (kp.row),
      .q     (rs)
   );

   assign dec          = row_decode(rs);
   assign tick_c       = (slot_cnt == SLOT_W'(SCAN_DIV - 1));
   assign cand_high_c  = rs[cand_row];
   assign cand_match_c = (rs == ~(4'b0001 << cand_row));
   assign db_last_c    = (db_cnt == DB_W'(DB_CNT - 1));

   // Slot timer, column strobe and key FSM; all decisions happen on the sample tick.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= SCAN;
         slot_cnt    <= '0;
         db_cnt      <= '0;
         col_idx     <= 2'd0;
         col_q       <= 4'b1110;
         cand_row    <= 2'd0;
         cand_col    <= 2'd0;
         key_hex_q   <= 4'h0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         rpt_cnt     <= '0;
         rpt_armed   <= 1'b0;
`endif
      end else begin
         key_valid_q <= 1'b0;
         slot_cnt    <= tick_c ? '0 : slot_cnt + SLOT_W'(1);
         if (tick_c) begin
            unique case (state)
               SCAN: begin
                  if (dec.single) begin
                     cand_row <= dec.idx;
                     cand_col <= col_idx;
                     db_cnt   <= DB_W'(1);
                     state    <= DEBOUNCE;
                  end else begin
                     col_q   <= {col_q[2:0], col_q[3]};
                     col_idx <= col_idx + 2'd1;
                  end
               end
               DEBOUNCE: begin
                  if (!cand_match_c) begin
                     state   <= SCAN;
                     col_q   <= {col_q[2:0], col_q[3]};
                     col_idx <= col_idx + 2'd1;
                  end else if (db_last_c) begin
                     state       <= HELD;
                     key_valid_q <= 1'b1;
                     key_hex_q   <= key_map(cand_row, cand_col);
                     key_held_q  <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                     rpt_cnt     <= '0;
                     rpt_armed   <= 1'b0;
`endif
                  end else begin
                     db_cnt <= db_cnt + DB_W'(1);
                  end
               end
               HELD: begin
                  if (cand_high_c) begin
                     db_cnt <= DB_W'(1);
                     state  <= RELEASE;
                  end
`ifdef KEYPAD_REPEAT_EN
                  else if (rpt_cnt == RPT_W'((rpt_armed ? REPEAT_RATE : REPEAT_DLY) - 1)) begin
                     key_valid_q <= 1'b1;
                     rpt_cnt     <= '0;
                     rpt_armed   <= 1'b1;
                  end else begin
                     rpt_cnt <= rpt_cnt + RPT_W'(1);
                  end
`endif
               end
               RELEASE: begin
                  if (!cand_high_c) begin
                     // Release bounce: back to held without a new key report.
                     state <= HELD;
`ifdef KEYPAD_REPEAT_EN
                     rpt_cnt   <= '0;
                     rpt_armed <= 1'b0;
`endif
                  end else if (db_last_c) begin
                     key_held_q <= 1'b0;
                     state      <= SCAN;
                     col_q      <= {col_q[2:0], col_q[3]};
                     col_idx    <= col_idx + 2'd1;
                  end else begin
                     db_cnt <= db_cnt + DB_W'(1);
                  end
               end
            endcase
         end
      end
   end

   assign kp.col       = col_q;
   assign kp.key_hex   = key_hex_q;
   assign kp.key_valid = key_valid_q;
   assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_hex.sv
// Scoreboard bench for keypad_scan_hex: a keypad matrix model drives rows from the
// column strobe; expected key codes are queued at press time and popped on key_valid.
module tb_keypad_scan_hex;
   localparam int unsigned SCAN_DIV    = 4;
   localparam int unsigned DB_CNT      = 3;
   localparam int unsigned REPEAT_DLY  = 5;
   localparam int unsigned REPEAT_RATE = 2;

   localparam logic [3:0] TB_MAP [4][4] = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{4'hE, 4'h0, 4'hF, 4'hD}
   };

   logic clk = 1'b0;
   logic reset;
   keypad_scan_hex_if kp();

   keypad_scan_hex #(
      .SCAN_DIV    (SCAN_DIV),
      .DB_CNT      (DB_CNT),
      .REPEAT_DLY  (REPEAT_DLY),
      .REPEAT_RATE (REPEAT_RATE)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .kp    (kp)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Physical keypad: a row reads low when any pressed key in it sits on a driven column.
   logic [3:0] pressed [4];
   logic [3:0] row_m;
   always_comb begin
      row_m = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r][c] && kp.col[c] == 1'b0) row_m[r] = 1'b0;
   end
   assign kp.row = row_m;

   logic [3:0] exp_q [$];
   int n_checks = 0;
   int n_fail   = 0;
`ifdef KEYPAD_REPEAT_EN
   logic [3:0] last_exp = 4'h0;
   int last_valid_cyc = 0;
   int n_rep = 0;
   int n_rep_total = 0;
`endif

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   task automatic check_range(input string name, input int val, input int lo, input int hi);
      n_checks++;
      if (val < lo || val > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, val, lo, hi, cyc);
      end
   endtask

   // Monitor: every key_valid must match the oldest queued expectation.
   always @(negedge clk) begin
      if (reset === 1'b0 && kp.key_valid === 1'b1) begin
         if (exp_q.size() > 0) begin
`ifdef KEYPAD_REPEAT_EN
            last_exp = exp_q[0];
            n_rep = 0;
            last_valid_cyc = cyc;
`endif
            check("key_hex", 32'(kp.key_hex), 32'(exp_q.pop_front()));
            check("held_at_valid", 32'(kp.key_held), 32'd1);
         end else begin
`ifdef KEYPAD_REPEAT_EN
            check("repeat_hex", 32'(kp.key_hex), 32'(last_exp));
            check("repeat_gap", 32'(cyc - last_valid_cyc),
                  32'((n_rep == 0 ? REPEAT_DLY : REPEAT_RATE) * SCAN_DIV));
            n_rep++;
            n_rep_total++;
            last_valid_cyc = cyc;
`else
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_valid: got key_hex 0x%0h, expected no pulse (cycle %0d)",
                     kp.key_hex, cyc);
`endif
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic release_all();
      for (int r = 0; r < 4; r++) pressed[r] = 4'h0;
   endtask

   task automatic wait_held(input logic v, input int limit, input string name, output int at_cyc);
      int n;
      n = 0;
      while (kp.key_held !== v && n < limit) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(kp.key_held === v), 32'd1);
      at_cyc = cyc;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_col"}, 32'(kp.col), 32'(4'b1110));
      check({tag, "_valid"}, 32'(kp.key_valid), 32'd0);
      check({tag, "_hex"}, 32'(kp.key_hex), 32'd0);
      check({tag, "_held"}, 32'(kp.key_held), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t0, t1, chg, r, c;
      logic [3:0] prev, e;
`ifdef KEYPAD_REPEAT_EN
      int rep0;
`endif
      release_all();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      reset = 1'b0;

      // Idle scan: column k/4 is active on the k-th negedge after reset release.
      for (int k = 0; k <= 16; k++) begin
         e = ~(4'b0001 << ((k / 4) % 4));
         check("col_seq", 32'(kp.col), 32'(e));
         @(negedge clk);
      end

      // Clean press of "5"; release debounce resumes scanning at col2.
      idle($urandom_range(0, 7));
      exp_q.push_back(TB_MAP[1][1]);
      pressed[1][1] = 1'b1;
      t0 = cyc;
      wait_held(1'b1, 200, "press5_held", t1);
      check_range("press5_latency", t1 - t0, 11, 31);
      idle(40);
      release_all();
      t0 = cyc;
      wait_held(1'b0, 60, "rel5_held", t1);
      check_range("rel5_latency", t1 - t0, 11, 14);
      check("rel5_col", 32'(kp.col), 32'(4'b1011));
      check("rel5_hex_kept", 32'(kp.key_hex), 32'(TB_MAP[1][1]));

      // Bouncy press of "0".
      idle($urandom_range(0, 7));
      exp_q.push_back(TB_MAP[3][1]);
      for (int i = 0; i < 8; i++) begin
         pressed[3][1] = ~pressed[3][1];
         idle($urandom_range(1, 3));
      end
      pressed[3][1] = 1'b1;
      wait_held(1'b1, 300, "press0_held", t1);
      idle(20);
      release_all();
      wait_held(1'b0, 60, "rel0_held", t1);
      check("rel0_hex", 32'(kp.key_hex), 32'(TB_MAP[3][1]));

      // Two rows low in column 0: no report, scanning never stalls.
      idle(8);
      pressed[0][0] = 1'b1;
      pressed[1][0] = 1'b1;
      idle(4);
      chg = 0;
      prev = kp.col;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (kp.col != prev) chg++;
         prev = kp.col;
      end
      check("multi_col_changes", 32'(chg), 32'd16);
      check("multi_held", 32'(kp.key_held), 32'd0);
      release_all();

      // "D" held, then "A" in the same column: only D is reported.
      idle(8);
      exp_q.push_back(TB_MAP[3][3]);
      pressed[3][3] = 1'b1;
      wait_held(1'b1, 200, "pressD_held", t1);
      pressed[0][3] = 1'b1;
      idle(40);
      release_all();
      wait_held(1'b0, 60, "relD_held", t1);
      idle(40);
      check("ghost_hex", 32'(kp.key_hex), 32'(TB_MAP[3][3]));

      // Reset while held: outputs clear, key is re-accepted once.
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      exp_q.push_back(TB_MAP[r][c]);
      pressed[r][c] = 1'b1;
      wait_held(1'b1, 200, "pre_rst_held", t1);
      idle(8);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_outputs("midrst");
      exp_q.push_back(TB_MAP[r][c]);
      reset = 1'b0;
      wait_held(1'b1, 200, "post_rst_held", t1);
      idle(10);
      release_all();
      wait_held(1'b0, 60, "post_rst_rel", t1);

      // "F" held for 20 ticks.
      idle(8);
`ifdef KEYPAD_REPEAT_EN
      rep0 = n_rep_total;
`endif
      exp_q.push_back(TB_MAP[3][2]);
      pressed[3][2] = 1'b1;
      wait_held(1'b1, 200, "pressF_held", t1);
      idle(80);
      release_all();
      wait_held(1'b0, 60, "relF_held", t1);
      idle(8);
`ifdef KEYPAD_REPEAT_EN
      check("repeat_count", 32'(n_rep_total - rep0), 32'd8);
`endif

      // Random single-key presses; scanning resumes at the column after the key.
      for (int n = 0; n < 6; n++) begin
         r = $urandom_range(0, 3);
         c = $urandom_range(0, 3);
         idle($urandom_range(0, 9));
         exp_q.push_back(TB_MAP[r][c]);
         pressed[r][c] = 1'b1;
         wait_held(1'b1, 200, "rand_held", t1);
         idle($urandom_range(4, 40));
         release_all();
         wait_held(1'b0, 60, "rand_rel", t1);
         e = ~(4'b0001 << ((c + 1) % 4));
         check("rand_rel_col", 32'(kp.col), 32'(e));
      end

      idle(20);
      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
